// File: rtl/gain_ramp.sv
`default_nettype none
// ============================================================================
// gain_ramp : slews the attenuator gain coefficient one LSB per prescaled
//             sample tick toward a clamped, mute-aware target.
// Rev 1.0
// ============================================================================
module gain_ramp #(
  parameter int MULT_W = 9,
  parameter int RATE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sample_tick_i,
  input  logic [MULT_W-1:0] target_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic              mute_i,
  output logic [MULT_W-1:0] mult_o,
  output logic              busy_o,
  output logic              muted_o
);

  localparam logic [MULT_W-1:0] UNITY = {1'b1, {(MULT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_MUTED     = 2'd0,
    ST_STEADY    = 2'd1,
    ST_RAMP_UP   = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [MULT_W-1:0] mult_q, mult_d;
  logic [RATE_W-1:0] presc_q, presc_d;
  logic              busy_q, muted_q;
  logic [MULT_W-1:0] eff;
  logic              in_ramp, tick_due, step_up, step_dn;

  always_comb begin
    eff = '0;
    if (!mute_i) eff = (target_i > UNITY) ? UNITY : target_i;
  end

  always_comb begin
    if (eff > mult_q)                 state_d = ST_RAMP_UP;
    else if (eff < mult_q)            state_d = ST_RAMP_DOWN;
    else if (mult_q == '0 && mute_i)  state_d = ST_MUTED;
    else                              state_d = ST_STEADY;
  end

  // A step only fires when the live direction still agrees with the current
  // ramp state, so a mid-ramp target change can never push past eff.
  always_comb begin
    in_ramp  = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    tick_due = sample_tick_i && (presc_q >= rate_i);
    step_up  = (state_q == ST_RAMP_UP)   && (state_d == ST_RAMP_UP)   && tick_due;
    step_dn  = (state_q == ST_RAMP_DOWN) && (state_d == ST_RAMP_DOWN) && tick_due;
  end

  always_comb begin
    presc_d = presc_q;
    if (state_d != state_q)              presc_d = '0;
    else if (in_ramp && sample_tick_i)   presc_d = tick_due ? '0 : presc_q + RATE_W'(1);
  end

  always_comb begin
    mult_d = mult_q;
    if (step_up)      mult_d = mult_q + MULT_W'(1);
    else if (step_dn) mult_d = mult_q - MULT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_MUTED;
      mult_q  <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
      muted_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mult_q  <= mult_d;
      presc_q <= presc_d;
      busy_q  <= (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
      muted_q <= (state_d == ST_MUTED);
    end
  end

  assign mult_o  = mult_q;
  assign busy_o  = busy_q;
  assign muted_o = muted_q;

  a_never_above_unity : assert property (@(posedge clk_i) disable iff (!rst_ni)
    mult_q <= UNITY);

  a_single_lsb_step : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mult_q == $past(mult_q)) || (mult_q == $past(mult_q) + MULT_W'(1)) ||
    (mult_q == $past(mult_q) - MULT_W'(1)));

endmodule
`default_nettype wire

// File: tb/tb_gain_ramp.sv
`default_nettype none
// ============================================================================
// tb_gain_ramp : scoreboard bench for gain_ramp against an integer model.
// Rev 1.0
// ============================================================================
module tb_gain_ramp;

  localparam int MULT_W = 9;
  localparam int RATE_W = 8;
  localparam int UNITY  = 256;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b1;
  logic              sample_tick_i = 1'b0;
  logic [MULT_W-1:0] target_i = 9'd256;
  logic [RATE_W-1:0] rate_i = '0;
  logic              mute_i = 1'b0;
  logic [MULT_W-1:0] mult_o;
  logic              busy_o;
  logic              muted_o;

  gain_ramp #(.MULT_W(MULT_W), .RATE_W(RATE_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sample_tick_i (sample_tick_i),
    .target_i      (target_i),
    .rate_i        (rate_i),
    .mute_i        (mute_i),
    .mult_o        (mult_o),
    .busy_o        (busy_o),
    .muted_o       (muted_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [MULT_W-1:0] mult;
    logic              busy;
    logic              muted;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   tick_cnt = 0;

  // Reference model: a level, a direction of travel (+1/-1/0), a muted flag
  // and a count of ticks since the last step.
  int m_level = 0;
  int m_dir   = 0;
  bit m_muted = 1'b1;
  int m_cnt   = 0;

  always @(posedge clk_i) begin
    int goal, want;
    bit mute_now;
    exp_t e;
    if (!rst_ni) begin
      m_level = 0; m_dir = 0; m_muted = 1'b1; m_cnt = 0;
    end else begin
      goal     = mute_i ? 0 : ((int'(target_i) > UNITY) ? UNITY : int'(target_i));
      want     = (goal > m_level) ? 1 : ((goal < m_level) ? -1 : 0);
      mute_now = (want == 0) && (m_level == 0) && mute_i;
      if (want != m_dir || mute_now != m_muted) begin
        m_cnt = 0;
      end else if (m_dir != 0 && sample_tick_i) begin
        if (m_cnt >= int'(rate_i)) begin
          m_level = m_level + m_dir;
          m_cnt   = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      m_dir   = want;
      m_muted = mute_now;
    end
    e.mult  = MULT_W'(m_level);
    e.busy  = (m_dir != 0);
    e.muted = m_muted;
    exp_q.push_back(e);
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (mult_o !== e.mult || busy_o !== e.busy || muted_o !== e.muted) begin
        n_err++;
        $display("FAIL outputs t=%0t: mult/busy/muted got %0d/%b/%b expected %0d/%b/%b",
                 $time, mult_o, busy_o, muted_o, e.mult, e.busy, e.muted);
      end
    end
  end

  task automatic cyc(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      tick_cnt++;
      if (period == 0) sample_tick_i = ($urandom_range(0, 3) == 0);
      else             sample_tick_i = ((tick_cnt % period) == 0);
    end
  endtask

  task automatic wait_level(input int lvl, input int budget);
    int guard = 0;
    while (int'(mult_o) != lvl && guard < budget) begin
      cyc(1, 1);
      guard++;
    end
    if (int'(mult_o) != lvl) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_level: mult_o=%0d never reached %0d", mult_o, lvl);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    #1 rst_ni = 1'b0;
    cyc(4, 4);
    @(negedge clk_i); #2 rst_ni = 1'b1;

    // Fade in from reset to unity, one step per tick.
    cyc(1100, 4);

    // Slow descent to 200 at four ticks per step.
    target_i = 9'd200; rate_i = 8'd3;
    cyc(470, 2);

    // Down to 128, then mute to zero and let ticks keep arriving.
    target_i = 9'd128; rate_i = 8'd0;
    cyc(160, 2);
    mute_i = 1'b1;
    cyc(280, 2);

    // Clamp: an over-range target must settle at unity.
    mute_i = 1'b0; target_i = 9'd250;
    cyc(260, 1);
    target_i = 9'd511;
    cyc(20, 1);

    // Mid-ramp reversal at 50 toward 10.
    mute_i = 1'b1;
    cyc(270, 1);
    mute_i = 1'b0; target_i = 9'd256;
    wait_level(50, 400);
    target_i = 9'd10;
    cyc(80, 1);

    // Asynchronous reset while ramping through 77.
    mute_i = 1'b1;
    cyc(20, 1);
    mute_i = 1'b0; target_i = 9'd256;
    wait_level(77, 400);
    @(negedge clk_i); #1 rst_ni = 1'b0;
    #1;
    n_vec++;
    if (mult_o !== 9'd0 || muted_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: mult/busy/muted got %0d/%b/%b expected 0/0/1",
               mult_o, busy_o, muted_o);
    end
    cyc(3, 1);
    @(negedge clk_i); #2 rst_ni = 1'b1;
    cyc(100, 1);

    // Randomised targets, rates, mute and tick spacing.
    for (int blk = 0; blk < 75; blk++) begin
      target_i = MULT_W'($urandom_range(0, 511));
      rate_i   = RATE_W'($urandom_range(0, 3));
      mute_i   = ($urandom_range(0, 4) == 0);
      cyc(40, 0);
    end

    cyc(2, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
